// File: rtl/spram_byte_fifo_pkg.sv
// Shared sizing constants and the RAM port-operation encoding for spram_byte_fifo.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package spram_fifo_pkg;

  // Default RAM word address width; one byte per 16-bit word.
  localparam int SPRAM_ADDR_W = 14;
  localparam int SPRAM_DEPTH  = 2 ** SPRAM_ADDR_W;

  // What the single SPRAM port does in a given cycle.
  typedef enum logic [1:0] {
    OP_IDLE  = 2'd0,
    OP_WRITE = 2'd1,
    OP_READ  = 2'd2
  } port_op_e;

endpackage

// File: rtl/spram_byte_fifo_if.sv
// Writer/reader bundle for spram_byte_fifo; overflow exists only with SPRAM_BYTE_FIFO_OVF_EN.
// Latency: wires only.
// Backpressure: writer must sample full in the cycle before strobing; read_strobe without data is ignored.
interface spram_byte_fifo_if import spram_fifo_pkg::*; #(
  parameter int ADDR_W = SPRAM_ADDR_W
);
  logic [7:0]      write_data;
  logic            write_strobe;
  logic            full;
  logic            data_available;
  logic [7:0]      read_data;
  logic            read_strobe;
  logic [ADDR_W:0] count;
`ifdef SPRAM_BYTE_FIFO_OVF_EN
  logic            overflow;
`endif

  // Writer/reader side.
  modport master (
    output write_data, write_strobe, read_strobe,
    input  full, data_available, read_data, count
`ifdef SPRAM_BYTE_FIFO_OVF_EN
    , input overflow
`endif
  );

  // FIFO side.
  modport slave (
    input  write_data, write_strobe, read_strobe,
    output full, data_available, read_data, count
`ifdef SPRAM_BYTE_FIFO_OVF_EN
    , output overflow
`endif
  );

endinterface

// File: rtl/spram_byte_fifo_ram.sv
// Wrapper around the 16Kx16 SB_SPRAM256KA; this body is the behavioural stand-in used in simulation.
// Latency: read data appears on o_rdata the cycle after a chip-selected read.
// Backpressure: none; one access per cycle, write wins when i_wren is high.
module spram_16k_wrapper import spram_fifo_pkg::*; #(
  parameter int ADDR_W = SPRAM_ADDR_W
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [15:0]       i_wdata,
  input  logic [3:0]        i_maskwren,
  input  logic              i_wren,
  input  logic              i_cs,
  output logic [15:0]       o_rdata
);

  logic [15:0] r_mem [2**ADDR_W];
  logic [15:0] r_rdata;

  // Nibble-masked write, or registered read of the addressed word.
  always_ff @(posedge clk) begin
    if (i_cs && i_wren) begin
      for (int i = 0; i < 4; i++) begin
        if (i_maskwren[i]) r_mem[i_addr][4*i +: 4] <= i_wdata[4*i +: 4];
      end
    end else if (i_cs) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/spram_byte_fifo.sv
// Byte FIFO on one single-port SPRAM; write and read may strobe together. Optional SPRAM_BYTE_FIFO_OVF_EN adds sticky overflow.
// Latency: write to empty FIFO -> data_available 4 cycles later; consume -> next byte 2 cycles later.
// Backpressure: writes while full are dropped; pending writes take the RAM port ahead of refill reads.
module spram_byte_fifo import spram_fifo_pkg::*; #(
  parameter int ADDR_W = SPRAM_ADDR_W
) (
  input logic              clk,
  input logic              reset,
  spram_byte_fifo_if.slave bus
);

  localparam logic [ADDR_W:0]   L_DEPTH   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   L_CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] L_PTR_ONE = ADDR_W'(1);

  logic              r_pw_valid;
  logic [7:0]        r_pw_data;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_ram_cnt;
  logic              r_rd_inflight;
  logic              r_dav;
  logic [7:0]        r_rdata;
  logic [ADDR_W:0]   r_count;
  logic              r_full;

  port_op_e          w_op;
  logic              w_accept;
  logic              w_consume;
  logic [ADDR_W:0]   w_count_nxt;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [15:0]       w_ram_rdata;
  logic              w_unused;

  assign w_accept  = bus.write_strobe && !r_full;
  assign w_consume = bus.read_strobe && r_dav;

  // Fixed-priority port schedule: drain the pending write first, then refill the output register.
  always_comb begin
    w_op = OP_IDLE;
    if (r_pw_valid) begin
      w_op = OP_WRITE;
    end else if ((r_ram_cnt != '0) && !r_rd_inflight && (!r_dav || w_consume)) begin
      w_op = OP_READ;
    end
  end

  assign w_ram_addr = (w_op == OP_READ) ? r_rd_ptr : r_wr_ptr;

  spram_16k_wrapper #(.ADDR_W(ADDR_W)) u_ram (
    .clk        (clk),
    .i_addr     (w_ram_addr),
    .i_wdata    ({8'h00, r_pw_data}),
    .i_maskwren (4'hF),
    .i_wren     (w_op == OP_WRITE),
    .i_cs       (1'b1),
    .o_rdata    (w_ram_rdata)
  );

  // High byte of each word is always written as zero and never read back.
  assign w_unused = ^w_ram_rdata[15:8];

  // Pending-write register, ring pointers and RAM occupancy follow the port schedule.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pw_valid    <= 1'b0;
      r_pw_data     <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_ram_cnt     <= '0;
      r_rd_inflight <= 1'b0;
    end else begin
      r_pw_valid    <= w_accept;
      if (w_accept) r_pw_data <= bus.write_data;
      r_rd_inflight <= (w_op == OP_READ);
      if (w_op == OP_WRITE) begin
        r_wr_ptr  <= r_wr_ptr + L_PTR_ONE;
        r_ram_cnt <= r_ram_cnt + L_CNT_ONE;
      end else if (w_op == OP_READ) begin
        r_rd_ptr  <= r_rd_ptr + L_PTR_ONE;
        r_ram_cnt <= r_ram_cnt - L_CNT_ONE;
      end
    end
  end

  // Output register: capture the returning RAM word, otherwise release the head on consume.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dav   <= 1'b0;
      r_rdata <= '0;
    end else if (r_rd_inflight) begin
      r_dav   <= 1'b1;
      r_rdata <= w_ram_rdata[7:0];
    end else if (w_consume) begin
      r_dav   <= 1'b0;
    end
  end

  assign w_count_nxt = r_count + (w_accept ? L_CNT_ONE : '0) - (w_consume ? L_CNT_ONE : '0);

  // Occupancy and full are registered views of accepted-minus-consumed bytes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
      r_full  <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == L_DEPTH);
    end
  end

`ifdef SPRAM_BYTE_FIFO_OVF_EN
  logic r_overflow;

  // Sticky flag for any write attempted while full.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overflow <= 1'b0;
    end else if (bus.write_strobe && r_full) begin
      r_overflow <= 1'b1;
    end
  end

  assign bus.overflow = r_overflow;
`endif

  assign bus.full           = r_full;
  assign bus.count          = r_count;
  assign bus.data_available = r_dav;
  assign bus.read_data      = r_rdata;

endmodule
